// File: rtl/shift_word_deserializer.sv
// ---------------------------------------------------------------------------
// shift_word_deserializer
//
// Serial-to-parallel receiver for the parallel-load shift-register link.
// Bits arrive LSB first, one per shift strobe. Each group of WIDTH bits is
// reassembled into a word and offered on a ready/valid parallel port. If a
// word completes while the previous one is still waiting to be consumed, the
// new word is dropped and a sticky overrun flag is raised.
//
// Ports
//   clk        rising-edge clock, shared with the transmitter
//   rst        synchronous, active-high reset (priority over everything)
//   shift      bit strobe; SI is sampled on each edge where shift=1
//   SI         serial data from the transmitter's SO
//   sync       word-boundary marker; restarts the bit count
//   D          received word, valid while out_valid=1
//   out_valid  D holds an unconsumed word
//   out_ready  consumer accepts D on an edge where out_valid=1
//   overrun    sticky; a completed word was dropped
//   bit_cnt    bits collected toward the current word (0..WIDTH-1)
// ---------------------------------------------------------------------------
module shift_word_deserializer #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             SI,
    input  logic             sync,
    output logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             complete;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the branches below can leave one unassigned and infer a latch.
        s_d       = s_q;
        d_d       = d_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;

        if (shift) begin
            s_d = {SI, s_q[WIDTH-1:1]};
            if (sync) begin
                // The bit sampled alongside sync is bit 0 of a fresh word.
                cnt_d = CW'(1);
            end else if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (sync) begin
            // Partial word is abandoned; S keeps its contents and is simply
            // overwritten by the next WIDTH shifts.
            cnt_d = '0;
        end

        if (complete) begin
            // A pending word that is being accepted this same edge frees the
            // slot, so only an unaccepted pending word causes a drop.
            if (valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                d_d     = s_d;
                valid_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            d_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s_q       <= s_d;
            d_q       <= d_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign D         = d_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_shift_word_deserializer.sv
// ---------------------------------------------------------------------------
// tb_shift_word_deserializer
//
// Directed scenarios with literal expectations, followed by a randomized
// stream. A queue-based model of the received bit stream predicts D,
// out_valid, overrun and bit_cnt after every clock edge.
// ---------------------------------------------------------------------------
module tb_shift_word_deserializer;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             shift = 1'b0;
    logic             SI = 1'b0;
    logic             sync = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] D;
    logic             out_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    shift_word_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift),
        .SI        (SI),
        .sync      (sync),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: bits of the word in progress, oldest first.
    bit q_bits[$];
    int m_d     = 0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit sh, input bit si, input bit sy, input bit rdy);
        bit done;
        int word;
        done = 1'b0;
        word = 0;
        if (r) begin
            q_bits.delete();
            m_d     = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (sh) begin
                if (sy) q_bits.delete();
                q_bits.push_back(si);
                if (q_bits.size() == WIDTH) begin
                    // First-received bit is the word's LSB.
                    foreach (q_bits[i]) word += int'(q_bits[i]) << i;
                    q_bits.delete();
                    done = 1'b1;
                end
            end else if (sy) begin
                q_bits.delete();
            end
            if (done) begin
                if (m_valid && !rdy) m_ovr = 1'b1;
                else begin
                    m_d     = word;
                    m_valid = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare();
        check("D",         int'(D),         m_d);
        check("out_valid", int'(out_valid), int'(m_valid));
        check("overrun",   int'(overrun),   int'(m_ovr));
        check("bit_cnt",   int'(bit_cnt),   q_bits.size());
    endtask

    // One clock: drive on negedge, model the rising edge, sample 1 ns later.
    task automatic cyc(input bit r, input bit sh, input bit si, input bit sy, input bit rdy);
        @(negedge clk);
        rst = r; shift = sh; SI = si; sync = sy; out_ready = rdy;
        @(posedge clk);
        model_edge(r, sh, si, sy, rdy);
        #1;
        compare();
    endtask

    task automatic shift_bits(input logic [WIDTH-1:0] bits_lsb_first, input bit rdy);
        for (int i = 0; i < WIDTH; i++) cyc(1'b0, 1'b1, bits_lsb_first[i], 1'b0, rdy);
    endtask

    initial begin
        // Reset held with shift=1, SI=1 must keep everything at zero.
        cyc(1, 1, 1, 0, 0);
        check("rst_D", int'(D), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        cyc(1, 1, 1, 0, 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_overrun", int'(overrun), 0);

        // Single word 1010: SI 0,1,0,1.
        cyc(0, 0, 0, 1, 0);
        shift_bits(4'b1010, 0);
        check("single_D", int'(D), 'b1010);
        check("single_valid", int'(out_valid), 1);
        cyc(0, 0, 0, 0, 1);
        check("single_accept", int'(out_valid), 0);

        // Continuous stream with out_ready=1: 1,1,0,0 then 1,0,0,1.
        shift_bits(4'b0011, 1);
        check("stream_D0", int'(D), 'b0011);
        check("stream_valid0", int'(out_valid), 1);
        shift_bits(4'b1001, 1);
        check("stream_D1", int'(D), 'b1001);
        check("stream_valid1", int'(out_valid), 1);
        check("stream_ovr", int'(overrun), 0);

        // Resync: two bits, then sync+shift, then three more bits.
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        check("resync_cnt2", int'(bit_cnt), 2);
        cyc(0, 1, 1, 1, 1);
        check("resync_cnt1", int'(bit_cnt), 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        check("resync_D", int'(D), 'b1101);

        // Overrun: 1010 unconsumed, then 0101 completes and is dropped.
        cyc(0, 0, 0, 1, 1);
        shift_bits(4'b1010, 0);
        shift_bits(4'b0101, 0);
        check("ovr_D", int'(D), 'b1010);
        check("ovr_flag", int'(overrun), 1);
        cyc(0, 0, 0, 0, 1);
        check("ovr_accept", int'(out_valid), 0);
        check("ovr_sticky", int'(overrun), 1);

        // Reset mid-word with a pending word.
        shift_bits(4'b1010, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check("mid_cnt3", int'(bit_cnt), 3);
        check("mid_valid", int'(out_valid), 1);
        cyc(1, 0, 0, 0, 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_D", int'(D), 0);
        check("mid_rst_ovr", int'(overrun), 0);
        shift_bits(4'b0110, 0);
        check("mid_D", int'(D), 'b0110);

        // Randomized stream.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 9) == 0),
                1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
